tb_ctrl_periph: RTL
===================

Name: tb_ctrl_periph

Overview:
Memory-mapped testbench control peripheral inside the core testbench subsystem. It sits on the core data bus as a responder and decodes firmware stores into the harness status signals: tests_passed_o, tests_failed_o, exit_valid_o and exit_value_o. It also provides a stdout character channel and a cycle timer with a compare interrupt. The top-level testbench consumes the status outputs to end simulation.

Parameters:
STDOUT_ADDR, 32'h1000_0000, word address of the stdout character register (write-only).
STATUS_ADDR, 32'h2000_0000, word address of the pass/fail register (write-only).
EXIT_ADDR, 32'h2000_0004, word address of the exit register (write-only).
TIMER_BASE, 32'h1500_0000, base address of the timer block; CNT at +0, CMP at +4, CTRL at +8.
PASS_MAGIC, 32'd123456789, value written to STATUS that signals pass.
FAIL_MAGIC, 32'd1, value written to STATUS that signals fail.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
data_req_i  in  1  bus request
data_addr_i  in  32  byte address; bits [1:0] ignored
data_we_i  in  1  1 = write
data_be_i  in  4  byte enables
data_wdata_i  in  32  write data
data_hit_o  out  1  combinational: address matches a mapped register
data_gnt_o  out  1  grant
data_rvalid_o  out  1  response valid
data_rdata_o  out  32  read data
stdout_valid_o  out  1  one-cycle pulse per stdout write
stdout_char_o  out  8  character
tests_passed_o  out  1  sticky pass
tests_failed_o  out  1  sticky fail
exit_valid_o  out  1  sticky exit
exit_value_o  out  32  exit code
irq_timer_o  out  1  timer interrupt, level

Behaviour:
- Reset (async, rst_ni=0): all outputs 0. CNT=0, CMP=0, CTRL=0. Any pending response is dropped.
- Decode: data_hit_o is high when data_req_i=1 and the word address equals any of the six mapped registers. data_gnt_o = data_hit_o, so a hit is granted in the same cycle with zero wait states. Non-hits are never granted; they are left to the RAM.
- Response: data_rvalid_o is asserted exactly 1 cycle after each grant, including for writes. Back-to-back grants give back-to-back rvalids.
- Read data, registered in the grant cycle:
  - CNT, CMP and CTRL return their current values.
  - Reads of STDOUT, STATUS or EXIT return 32'h0.
  - data_rdata_o is 0 whenever rvalid=0.
- Side effects are applied on the grant-cycle clock edge:
  - STDOUT write with be[0]=1: stdout_valid_o=1 for 1 cycle starting the next cycle; stdout_char_o=wdata[7:0], held until the next stdout write. With be[0]=0, no pulse.
  - STATUS write, be ignored (full word): wdata==PASS_MAGIC sets tests_passed_o; wdata==FAIL_MAGIC sets tests_failed_o; any other value has no effect. Both flags are sticky until reset and can both end up set.
  - EXIT write, be ignored: exit_value_o=wdata and exit_valid_o=1. Both are sticky. Later EXIT writes are ignored (first value wins).
  - CNT/CMP/CTRL writes honour data_be_i per byte. CTRL[0] is EN; CTRL[31:1] read as 0.
- Timer:
  - When EN=1, CNT increments by 1 every cycle and wraps 32'hFFFF_FFFF -> 0. A bus write to CNT in the same cycle takes precedence over the increment.
  - irq_timer_o is set on the cycle after CNT==CMP while EN=1 and CMP!=0, and stays high until cleared.
  - irq_timer_o is cleared by any write to CMP or CTRL. When a clear coincides with a match, the clear wins.
  - EN=0 freezes CNT but does not clear an already-set irq.
- Simultaneous events: only one bus transaction per cycle is possible. The timer update and a bus transaction act in parallel, subject to the precedence rules above.
- Unknown or X data_addr_i while data_req_i=0 has no effect.

Test Plan:
- Reset release, idle bus for 10 cycles -> all outputs 0; data_hit_o=0 and data_gnt_o=0 for a req to 32'h0000_0180.
- Write 0x41 to STDOUT with be=4'b0001 -> gnt in the same cycle; rvalid plus stdout_valid_o pulse with char 8'h41 one cycle later; next cycle stdout_valid_o=0. The same write with be=4'b0010 -> no pulse.
- STATUS write 123456789 -> tests_passed_o=1, held for 100 cycles. STATUS write 7 -> no change. STATUS write 1 -> tests_failed_o=1, tests_passed_o still 1.
- EXIT write 32'h5 then EXIT write 32'h0 -> exit_valid_o=1, exit_value_o stays 5.
- CMP=20, CNT=0, CTRL=1 -> irq_timer_o rises exactly 21 cycles after the CTRL grant edge. CMP write in the cycle CNT==CMP -> irq stays 0.
- CNT=32'hFFFF_FFFE, EN=1, then read CNT 3 cycles later -> read returns the wrapped value (1 at the sample edge). A write of 32'h0000_00AA to CNT with be=4'b0001 during counting -> only byte 0 replaced, no increment that cycle.

Source files
------------

// File: rtl/tb_ctrl_periph.sv
// rtl/tb_ctrl_periph.sv - testbench control peripheral: stdout, pass/fail/exit status, cycle timer with compare irq
module tb_ctrl_periph #(
  parameter logic [31:0] STDOUT_ADDR = 32'h1000_0000,
  parameter logic [31:0] STATUS_ADDR = 32'h2000_0000,
  parameter logic [31:0] EXIT_ADDR   = 32'h2000_0004,
  parameter logic [31:0] TIMER_BASE  = 32'h1500_0000,
  parameter logic [31:0] PASS_MAGIC  = 32'd123456789,
  parameter logic [31:0] FAIL_MAGIC  = 32'd1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        data_req_i,
  input  logic [31:0] data_addr_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_hit_o,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        stdout_valid_o,
  output logic [7:0]  stdout_char_o,
  output logic        tests_passed_o,
  output logic        tests_failed_o,
  output logic        exit_valid_o,
  output logic [31:0] exit_value_o,
  output logic        irq_timer_o
);

  localparam logic [31:0] CNT_ADDR  = TIMER_BASE;
  localparam logic [31:0] CMP_ADDR  = TIMER_BASE + 32'd4;
  localparam logic [31:0] CTRL_ADDR = TIMER_BASE + 32'd8;

  logic [29:0] word;
  logic        sel_stdout, sel_status, sel_exit, sel_cnt, sel_cmp, sel_ctrl;
  logic        wr;
  logic [31:0] cnt, cmp;
  logic        en;
  logic [31:0] rd_next;
  logic        match;
  logic        irq_clear;
  logic        unused_addr_lsb;

  // Byte-lane merge of new data into an existing register value
  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] be);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      r[i*8 +: 8] = be[i] ? new_v[i*8 +: 8] : old_v[i*8 +: 8];
    end
    return r;
  endfunction

  // Byte offset within a word never affects decode
  assign unused_addr_lsb = ^data_addr_i[1:0];
  assign word = data_addr_i[31:2];

  assign sel_stdout = (word == STDOUT_ADDR[31:2]);
  assign sel_status = (word == STATUS_ADDR[31:2]);
  assign sel_exit   = (word == EXIT_ADDR[31:2]);
  assign sel_cnt    = (word == CNT_ADDR[31:2]);
  assign sel_cmp    = (word == CMP_ADDR[31:2]);
  assign sel_ctrl   = (word == CTRL_ADDR[31:2]);

  // Req gates the decode so an undriven address while idle never produces a hit
  assign data_hit_o = data_req_i &&
                      (sel_stdout || sel_status || sel_exit || sel_cnt || sel_cmp || sel_ctrl);
  assign data_gnt_o = data_hit_o;
  assign wr         = data_gnt_o && data_we_i;

  // Only timer registers are readable; status-style registers read as zero
  always_comb begin
    rd_next = 32'h0;
    if (sel_cnt)       rd_next = cnt;
    else if (sel_cmp)  rd_next = cmp;
    else if (sel_ctrl) rd_next = {31'h0, en};
  end

  assign match     = en && (cmp != 32'h0) && (cnt == cmp);
  assign irq_clear = wr && (sel_cmp || sel_ctrl);

  // Single-cycle response path; rdata is forced to zero when no response is due
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_rvalid_o <= 1'b0;
      data_rdata_o  <= 32'h0;
    end else begin
      data_rvalid_o <= data_gnt_o;
      data_rdata_o  <= data_gnt_o ? rd_next : 32'h0;
    end
  end

  // Harness status: stdout pulse plus sticky pass/fail/exit flags
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stdout_valid_o <= 1'b0;
      stdout_char_o  <= 8'h0;
      tests_passed_o <= 1'b0;
      tests_failed_o <= 1'b0;
      exit_valid_o   <= 1'b0;
      exit_value_o   <= 32'h0;
    end else begin
      stdout_valid_o <= wr && sel_stdout && data_be_i[0];
      if (wr && sel_stdout && data_be_i[0]) stdout_char_o <= data_wdata_i[7:0];
      if (wr && sel_status && (data_wdata_i == PASS_MAGIC)) tests_passed_o <= 1'b1;
      if (wr && sel_status && (data_wdata_i == FAIL_MAGIC)) tests_failed_o <= 1'b1;
      if (wr && sel_exit && !exit_valid_o) begin
        exit_valid_o <= 1'b1;
        exit_value_o <= data_wdata_i;
      end
    end
  end

  // Timer: a bus write to CNT overrides the increment; a CMP/CTRL write beats a match
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt         <= 32'h0;
      cmp         <= 32'h0;
      en          <= 1'b0;
      irq_timer_o <= 1'b0;
    end else begin
      if (wr && sel_cnt) cnt <= merge(cnt, data_wdata_i, data_be_i);
      else if (en)       cnt <= cnt + 32'd1;
      if (wr && sel_cmp) cmp <= merge(cmp, data_wdata_i, data_be_i);
      if (wr && sel_ctrl && data_be_i[0]) en <= data_wdata_i[0];
      if (irq_clear)  irq_timer_o <= 1'b0;
      else if (match) irq_timer_o <= 1'b1;
    end
  end

endmodule
